// File: rtl/pb_debounce.sv
// Push-button conditioner: two-flop synchronizer, restart-on-agree debounce,
// and a press/hold FSM emitting registered pressed/released/long_press strobes.
module pb_debounce #(
    parameter int unsigned DB_CYCLES   = 50000,
    parameter int unsigned LONG_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic PB_raw,
    output logic PB_clean,
    output logic pressed,
    output logic released,
    output logic long_press
);

    localparam int unsigned DW = $clog2(DB_CYCLES);
    localparam int unsigned HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DB_MAX   = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } state_e;

    logic          sync1_q, sync1_d;
    logic          s_q, s_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          clean_q, clean_d;
    state_e        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          pressed_q, pressed_d;
    logic          released_q, released_d;
    logic          long_q, long_d;

    always_comb begin
        sync1_d = PB_raw;
        s_d     = sync1_q;
    end

    always_comb begin
        db_cnt_d = db_cnt_q;
        clean_d  = clean_q;
        if (s_q == clean_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
            clean_d  = s_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // FSM looks at clean_d so each strobe lands in the same cycle PB_clean changes.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        long_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!clean_d) begin
                    state_d    = HELD;
                    hold_cnt_d = '0;
                    pressed_d  = 1'b1;
                end
            end
            HELD: begin
                if (clean_d) begin
                    state_d    = IDLE;
                    released_d = 1'b1;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (clean_d) begin
                    state_d    = IDLE;
                    released_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            s_q        <= 1'b1;
            db_cnt_q   <= '0;
            clean_q    <= 1'b1;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            s_q        <= s_d;
            db_cnt_q   <= db_cnt_d;
            clean_q    <= clean_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            long_q     <= long_d;
        end
    end

    assign PB_clean   = clean_q;
    assign pressed    = pressed_q;
    assign released   = released_q;
    assign long_press = long_q;

endmodule

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce (DB_CYCLES=4, LONG_CYCLES=20): expected strobe events are
// queued with their due cycle when stimulus is driven and compared every cycle.
module tb_pb_debounce;

    typedef enum logic [1:0] {EV_NONE, EV_PRESS, EV_RELEASE, EV_LONG} ev_e;

    typedef struct {
        logic        raw;
        int unsigned len;
        ev_e         ev;
        int unsigned lat;
    } seg_t;

    typedef struct {
        ev_e         kind;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic PB_raw = 1'b0;
    logic PB_clean, pressed, released, long_press;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    logic        exp_clean = 1'b1;
    exp_t        sb[$];
    seg_t        tbl[$];

    pb_debounce #(
        .DB_CYCLES  (4),
        .LONG_CYCLES(20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PB_raw    (PB_raw),
        .PB_clean  (PB_clean),
        .pressed   (pressed),
        .released  (released),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0b expected=%0b", name, cyc, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_e kind, input int unsigned lat);
        exp_t e;
        e.kind = kind;
        e.cyc  = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic check_cycle();
        logic ep, er, el;
        exp_t e;
        ep = 1'b0;
        er = 1'b0;
        el = 1'b0;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                EV_PRESS:   begin ep = 1'b1; exp_clean = 1'b0; end
                EV_RELEASE: begin er = 1'b1; exp_clean = 1'b1; end
                EV_LONG:    el = 1'b1;
                default:    ;
            endcase
        end
        check1("pressed", pressed, ep);
        check1("released", released, er);
        check1("long_press", long_press, el);
        check1("PB_clean", PB_clean, exp_clean);
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check_cycle();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check1({tag, "_clean"}, PB_clean, 1'b1);
        check1({tag, "_pressed"}, pressed, 1'b0);
        check1({tag, "_released"}, released, 1'b0);
        check1({tag, "_long"}, long_press, 1'b0);
    endtask

    task automatic add_seg(input logic raw, input int unsigned len, input ev_e ev,
                           input int unsigned lat);
        seg_t s;
        s.raw = raw;
        s.len = len;
        s.ev  = ev;
        s.lat = lat;
        tbl.push_back(s);
    endtask

    initial begin
        // Table: clean press/release, 3-sample bounce burst, exact 4-sample run.
        add_seg(1'b0, 10, EV_PRESS, 6);
        add_seg(1'b1, 12, EV_RELEASE, 6);
        for (int k = 0; k < 8; k++) begin
            add_seg(1'b0, 3, EV_NONE, 0);
            add_seg(1'b1, 2, EV_NONE, 0);
        end
        add_seg(1'b1, 10, EV_NONE, 0);
        add_seg(1'b0, 4, EV_PRESS, 6);
        add_seg(1'b1, 12, EV_RELEASE, 6);

        // Reset held with button pressed: no strobes, then one press after release.
        @(negedge clk);
        check_reset_values("in_reset");
        step(3);
        rst_n = 1'b1;
        expect_ev(EV_PRESS, 6);
        step(10);
        PB_raw = 1'b1;
        expect_ev(EV_RELEASE, 6);
        step(12);

        foreach (tbl[i]) begin
            PB_raw = tbl[i].raw;
            if (tbl[i].ev != EV_NONE) expect_ev(tbl[i].ev, tbl[i].lat);
            step(tbl[i].len);
        end

        // Long press: one long_press 20 cycles after pressed, none again.
        PB_raw = 1'b0;
        expect_ev(EV_PRESS, 6);
        expect_ev(EV_LONG, 26);
        step(40);
        PB_raw = 1'b1;
        expect_ev(EV_RELEASE, 6);
        step(15);

        // Reset asserted while in LONG: outputs clear without a clock edge.
        PB_raw = 1'b0;
        expect_ev(EV_PRESS, 6);
        expect_ev(EV_LONG, 26);
        step(30);
        check1("in_long_clean", PB_clean, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        sb.delete();
        exp_clean = 1'b1;
        PB_raw = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(5);
        PB_raw = 1'b0;
        expect_ev(EV_PRESS, 6);
        step(10);
        PB_raw = 1'b1;
        expect_ev(EV_RELEASE, 6);
        step(12);

        check1("scoreboard_drained", sb.size() == 0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
